// File: rtl/alu24_checker.sv
// alu24_checker: sequential response checker for the 24-bit ALU.
// Recomputes the expected ALU response from the stimulus, compares it with the
// observed bundle two cycles later and keeps saturating check/error totals,
// the index of the first failing vector and a final pass/fail verdict.
module alu24_checker #(
  parameter int WIDTH = 24,
  parameter int CNTW  = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BNegate,
  input  logic [2:0]       Op,
  input  logic [3:0]       shamt,
  input  logic [WIDTH-1:0] Result,
  input  logic             Zero,
  input  logic             Overflow,
  input  logic             CarryOut,
  output logic             chk_valid,
  output logic             mismatch,
  output logic [3:0]       mismatch_mask,
  output logic [CNTW-1:0]  checks_total,
  output logic [CNTW-1:0]  errors_total,
  output logic [CNTW-1:0]  first_fail_idx,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  localparam logic [CNTW-1:0] CNT_ONE = 1;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Mask bit positions: {Result, Zero, Overflow, CarryOut}
  localparam int M_RES  = 3;
  localparam int M_ZERO = 2;
  localparam int M_OVF  = 1;
  localparam int M_COUT = 0;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   drain_cnt_q, drain_cnt_d;
  logic   accept;

  // State register; the drain counter times the two DRAIN cycles.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (Reset) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state logic: start (re)enters RUN from anywhere; stop only acts in RUN.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (start) begin
      state_d     = ST_RUN;
      drain_cnt_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (stop) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = 1'b0;
          end
        end
        ST_DRAIN: begin
          // Two DRAIN cycles cover the two pipeline stages.
          if (drain_cnt_q) state_d     = ST_DONE;
          else             drain_cnt_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A vector is taken only while running; a start in the same cycle wins and
  // flushes, so the vector on the bus that cycle is dropped too.
  assign accept = (state_q == ST_RUN) && in_valid && !start;

  // ---------------------------------------------------------------------------
  // Stage 1: capture stimulus and observed response
  // ---------------------------------------------------------------------------
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b, s1_result;
  logic             s1_bneg, s1_zero, s1_ovf, s1_cout;
  logic [2:0]       s1_op;
  logic [3:0]       s1_shamt;

  // Stage-1 valid bit; cleared by reset and by a restart (accept is low then).
  always_ff @(posedge Clock) begin
    if (Reset) s1_valid <= 1'b0;
    else       s1_valid <= accept;
  end

  // Stage-1 payload; qualified by s1_valid, so it needs no reset value.
  always_ff @(posedge Clock) begin
    if (accept) begin
      s1_a      <= A;
      s1_b      <= B;
      s1_bneg   <= BNegate;
      s1_op     <= Op;
      s1_shamt  <= shamt;
      s1_result <= Result;
      s1_zero   <= Zero;
      s1_ovf    <= Overflow;
      s1_cout   <= CarryOut;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: expected response and field compare
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] exp_result;
  logic             exp_zero, exp_ovf, exp_cout, is_add;
  logic [3:0]       mask_d;

  // Reference ALU: result per opcode plus the adder-only flags.
  always_comb begin
    b_eff    = s1_b ^ {WIDTH{s1_bneg}};
    sum      = {1'b0, s1_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, s1_bneg};
    exp_cout = sum[WIDTH];
    exp_ovf  = (s1_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
    unique case (s1_op)
      OP_AND:  exp_result = s1_a & s1_b;
      OP_OR:   exp_result = s1_a | s1_b;
      OP_ADD:  exp_result = sum[WIDTH-1:0];
      OP_SLT:  exp_result = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      OP_XOR:  exp_result = s1_a ^ s1_b;
      OP_NOR:  exp_result = ~(s1_a | s1_b);
      OP_SLL:  exp_result = s1_b << s1_shamt;
      OP_SRL:  exp_result = s1_b >> s1_shamt;
      default: exp_result = '0;
    endcase
    exp_zero = (exp_result == '0);
  end

  // Field compare; Overflow/CarryOut are only meaningful for the adder op.
  always_comb begin
    is_add         = (s1_op == OP_ADD);
    mask_d         = 4'b0000;
    mask_d[M_RES]  = (s1_result != exp_result);
    mask_d[M_ZERO] = (s1_zero != exp_zero);
    mask_d[M_OVF]  = is_add && (s1_ovf  != exp_ovf);
    mask_d[M_COUT] = is_add && (s1_cout != exp_cout);
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers: check strobe, mask and running totals
  // ---------------------------------------------------------------------------
  logic fail_seen;

  // Totals move in the same cycle as chk_valid; start clears them and flushes.
  always_ff @(posedge Clock) begin
    if (Reset || start) begin
      chk_valid      <= 1'b0;
      mismatch       <= 1'b0;
      mismatch_mask  <= 4'b0000;
      checks_total   <= '0;
      errors_total   <= '0;
      first_fail_idx <= '1;
      fail_seen      <= 1'b0;
    end else begin
      chk_valid     <= s1_valid;
      mismatch      <= s1_valid && (|mask_d);
      mismatch_mask <= s1_valid ? mask_d : 4'b0000;
      if (s1_valid) begin
        if (checks_total != CNT_MAX) checks_total <= checks_total + CNT_ONE;
        if (|mask_d) begin
          if (errors_total != CNT_MAX) errors_total <= errors_total + CNT_ONE;
          // Index is the number of vectors checked before this one.
          if (!fail_seen) begin
            first_fail_idx <= checks_total;
            fail_seen      <= 1'b1;
          end
        end
      end
    end
  end

  // Verdict outputs are decoded from registered state and totals.
  assign done = (state_q == ST_DONE);
  assign pass = done && (errors_total == '0) && (checks_total != '0);

endmodule

// File: tb/tb_alu24_checker.sv
// Self-checking bench for alu24_checker: directed scenarios plus randomized
// vectors, compared every cycle against a behavioural model of the checker.
module tb_alu24_checker;

  localparam int WIDTH   = 24;
  localparam int CNTW    = 16;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  localparam longint TWO23 = 64'd8388608;
  localparam longint TWO24 = 64'd16777216;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic             Clock = 1'b0;
  logic             Reset, start, stop, in_valid;
  logic [WIDTH-1:0] A, B, Result;
  logic             BNegate, Zero, Overflow, CarryOut;
  logic [2:0]       Op;
  logic [3:0]       shamt;
  logic             chk_valid, mismatch, done, pass;
  logic [3:0]       mismatch_mask;
  logic [CNTW-1:0]  checks_total, errors_total, first_fail_idx;

  alu24_checker #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .stop(stop), .in_valid(in_valid),
    .A(A), .B(B), .BNegate(BNegate), .Op(Op), .shamt(shamt),
    .Result(Result), .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut),
    .chk_valid(chk_valid), .mismatch(mismatch), .mismatch_mask(mismatch_mask),
    .checks_total(checks_total), .errors_total(errors_total),
    .first_fail_idx(first_fail_idx), .done(done), .pass(pass)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             z, o, c;
  } resp_t;

  typedef struct {
    int         due;
    logic [3:0] mask;
  } pend_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         edge_n   = 0;
  pend_t      pend[$];
  int         m_state, m_drain, m_checks, m_errors, m_ffi;
  bit         m_seen;
  logic [3:0] cur_mask;
  logic       e_chk, e_mm;
  logic [3:0] e_mask;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Expected ALU response from plain integer arithmetic.
  function automatic resp_t ref_resp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic bn, input logic [2:0] op, input logic [3:0] sh);
    resp_t  r;
    longint ua, ub, ubp, sa, sb, sbp, s, ss;
    ua  = longint'(a);
    ub  = longint'(b);
    ubp = bn ? (ub ^ 64'hFFFFFF) : ub;
    sa  = (ua  >= TWO23) ? ua  - TWO24 : ua;
    sb  = (ub  >= TWO23) ? ub  - TWO24 : ub;
    sbp = (ubp >= TWO23) ? ubp - TWO24 : ubp;
    s   = ua + ubp + longint'(bn);
    ss  = sa + sbp + longint'(bn);
    r.o = 1'b0;
    r.c = 1'b0;
    case (op)
      3'd0: r.res = a & b;
      3'd1: r.res = a | b;
      3'd2: begin
        r.res = WIDTH'(s % TWO24);
        r.c   = (s >= TWO24);
        r.o   = (ss >= TWO23) || (ss < -TWO23);
      end
      3'd3: r.res = (sa < sb) ? 24'd1 : 24'd0;
      3'd4: r.res = a ^ b;
      3'd5: r.res = ~(a | b);
      3'd6: r.res = WIDTH'((ub * (64'd1 << sh)) % TWO24);
      default: r.res = WIDTH'(ub / (64'd1 << sh));
    endcase
    r.z = (r.res == 0);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_word();
    case ($urandom_range(0, 7))
      0: return 24'h000000;
      1: return 24'h7FFFFF;
      2: return 24'h800000;
      3: return 24'hFFFFFF;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic idle_bus();
    in_valid = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
  endtask

  // Drive one vector; corrupt: 0 none, 1 Result, 2 Zero, 3 Overflow, 4 CarryOut.
  task automatic put_vec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bn,
                         input logic [2:0] op, input logic [3:0] sh, input int corrupt);
    resp_t            r;
    logic [WIDTH-1:0] flip;
    r    = ref_resp(a, b, bn, op, sh);
    flip = WIDTH'($urandom_range(1, 32'hFFFFFF));
    A = a; B = b; BNegate = bn; Op = op; shamt = sh;
    Result = (corrupt == 1) ? (r.res ^ flip) : r.res;
    Zero   = r.z ^ (corrupt == 2);
    if (op == 3'd2) begin
      Overflow = r.o ^ (corrupt == 3);
      CarryOut = r.c ^ (corrupt == 4);
    end else begin
      Overflow = 1'($urandom);
      CarryOut = 1'($urandom);
    end
    in_valid = 1'b1;
    cur_mask = {Result != r.res, Zero != r.z,
                (op == 3'd2) && (Overflow != r.o), (op == 3'd2) && (CarryOut != r.c)};
  endtask

  task automatic put_rand(input int corrupt);
    put_vec(rnd_word(), rnd_word(), 1'($urandom), 3'($urandom), 4'($urandom), corrupt);
  endtask

  task automatic clear_model_totals();
    m_checks = 0;
    m_errors = 0;
    m_ffi    = CNT_MAX;
    m_seen   = 1'b0;
  endtask

  // Advance one clock: update the model for this edge, then compare all outputs.
  task automatic tick();
    pend_t e;
    e_chk  = 1'b0;
    e_mm   = 1'b0;
    e_mask = 4'b0000;
    if (Reset) begin
      pend.delete();
      m_state = M_IDLE;
      m_drain = 0;
      clear_model_totals();
    end else if (start) begin
      pend.delete();
      m_state = M_RUN;
      clear_model_totals();
    end else begin
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        e      = pend.pop_front();
        e_chk  = 1'b1;
        e_mask = e.mask;
        e_mm   = |e.mask;
        if (e_mm) begin
          if (!m_seen) begin
            m_ffi  = m_checks;
            m_seen = 1'b1;
          end
          if (m_errors < CNT_MAX) m_errors++;
        end
        if (m_checks < CNT_MAX) m_checks++;
      end
      if (m_state == M_RUN && in_valid) pend.push_back('{edge_n + 1, cur_mask});
      if (m_state == M_RUN && stop) begin
        m_state = M_DRAIN;
        m_drain = 0;
      end else if (m_state == M_DRAIN) begin
        m_drain++;
        if (m_drain == 2) m_state = M_DONE;
      end
    end
    @(posedge Clock);
    #1;
    edge_n++;
    check("chk_valid",      32'(chk_valid),      32'(e_chk));
    check("mismatch",       32'(mismatch),       32'(e_mm));
    check("mismatch_mask",  32'(mismatch_mask),  32'(e_mask));
    check("checks_total",   32'(checks_total),   32'(m_checks));
    check("errors_total",   32'(errors_total),   32'(m_errors));
    check("first_fail_idx", 32'(first_fail_idx), 32'(m_ffi));
    check("done",           32'(done),           32'(m_state == M_DONE));
    check("pass",           32'(pass),
          32'((m_state == M_DONE) && (m_errors == 0) && (m_checks != 0)));
  endtask

  initial begin
    Reset = 1'b1;
    idle_bus();
    A = '0; B = '0; BNegate = 1'b0; Op = '0; shamt = '0;
    Result = '0; Zero = 1'b0; Overflow = 1'b0; CarryOut = 1'b0;
    cur_mask = '0;
    repeat (3) tick();
    check("reset_ffi_ones", 32'(first_fail_idx), 32'hFFFF);
    Reset = 1'b0;
    tick();

    // in_valid while IDLE is ignored
    repeat (3) begin
      put_rand(0);
      tick();
    end
    idle_bus();
    tick();
    tick();
    check("idle_checks_zero", 32'(checks_total), 32'd0);

    // Run 1: directed passing vectors, then stop
    start = 1'b1;
    tick();
    start = 1'b0;
    put_vec(24'd2, 24'd10, 1'b0, 3'd6, 4'd2, 0);
    tick();
    put_vec(24'd10, 24'd8, 1'b1, 3'd2, 4'd0, 0);
    tick();
    check("sll_chk_valid", 32'(chk_valid), 32'd1);
    check("sll_checks", 32'(checks_total), 32'd1);
    put_vec(24'd10, 24'd10, 1'b1, 3'd2, 4'd0, 0);
    tick();
    put_vec(24'd5, 24'd10, 1'b1, 3'd2, 4'd0, 0);
    tick();
    idle_bus();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("run1_done_early", 32'(done), 32'd0);
    tick();
    check("run1_done", 32'(done), 32'd1);
    check("run1_pass", 32'(pass), 32'd1);
    check("run1_checks", 32'(checks_total), 32'd4);

    // Run 2: missed overflow on 0x7FFFFF + 1
    start = 1'b1;
    tick();
    start = 1'b0;
    put_vec(24'h7FFFFF, 24'd1, 1'b0, 3'd2, 4'd0, 3);
    tick();
    idle_bus();
    tick();
    check("ovf_mask", 32'(mismatch_mask), 32'h2);
    check("ovf_errors", 32'(errors_total), 32'd1);
    check("ovf_ffi", 32'(first_fail_idx), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();
    check("run2_pass_low", 32'(pass), 32'd0);

    // Run 3: 100 back-to-back vectors, vector 37 wrong, stop on the last one
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      put_rand((i == 37) ? 1 : 0);
      stop = (i == 99);
      tick();
    end
    stop = 1'b0;
    repeat (2) begin
      put_rand(0);
      tick();
    end
    idle_bus();
    repeat (2) tick();
    check("run3_checks", 32'(checks_total), 32'd100);
    check("run3_errors", 32'(errors_total), 32'd1);
    check("run3_ffi", 32'(first_fail_idx), 32'd37);
    check("run3_done", 32'(done), 32'd1);

    // Randomized phase with random restarts and stops
    start = 1'b1;
    tick();
    for (int c = 0; c < 600; c++) begin
      int r;
      idle_bus();
      r = int'($urandom_range(0, 99));
      if (r < 2 || ((m_state == M_IDLE || m_state == M_DONE) && r < 12)) begin
        start = 1'b1;
      end else begin
        if (r < 5) stop = 1'b1;
        if ($urandom_range(0, 3) != 0)
          put_rand(($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
      end
      tick();
    end

    // Reset with vectors in flight
    idle_bus();
    start = 1'b1;
    tick();
    start = 1'b0;
    put_rand(0);
    tick();
    put_rand(1);
    Reset = 1'b1;
    tick();
    check("rst_chk_valid", 32'(chk_valid), 32'd0);
    check("rst_checks", 32'(checks_total), 32'd0);
    idle_bus();
    Reset = 1'b0;
    repeat (3) tick();
    check("post_rst_chk_valid", 32'(chk_valid), 32'd0);
    check("post_rst_ffi", 32'(first_fail_idx), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
